// File: rtl/fifo_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_reader_if
//   Downstream stream handshake carried out of fifo_reader.
//   m_data  : registered data word
//   m_valid : m_data holds an undelivered entry
//   m_ready : consumer accepts m_data on an edge where m_valid is also high
//   master  : producer side (fifo_reader)
//   slave   : consumer side
// -----------------------------------------------------------------------------
interface fifo_reader_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//   Drains a companion synchronous fifo (combinational read data) into a
//   one-entry registered output stage. It tracks the fifo occupancy itself
//   from a copy of the write strobe, so pop is generated without any
//   handshake back from the fifo. A flush request discards everything
//   buffered, including pushes that arrive while flushing.
//
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   push       : copy of the fifo write strobe
//   fifo_dout  : fifo read data (entry at its read pointer)
//   pop        : fifo read strobe
//   flush      : request to discard all buffered entries
//   stream     : m_data / m_valid / m_ready output handshake
//   count      : entries in the fifo, not counting the one in m_data
//   empty/full : count == 0 / count == DEPTH
//   overflow   : sticky, push seen while full with no pop
//   flush_done : one-cycle pulse after a flush completes
// -----------------------------------------------------------------------------
module fifo_reader #(
  parameter int DEPTH = 256,
  parameter int SIZE  = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             pop,
  input  logic             flush,
  fifo_reader_if.master    stream,
  output logic [SIZE:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             flush_done
);

  localparam logic [SIZE:0] DEPTH_CNT = (SIZE+1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  state_t        state_next;
  logic          push_eff;
  logic [SIZE:0] count_next;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A push into a full fifo only lands if the same edge frees a slot.
  assign push_eff   = push && (!full || pop);
  assign count_next = count + (SIZE+1)'(push_eff) - (SIZE+1)'(pop);

  // NOTE: every signal driven from always_comb gets a default on entry;
  // any path that skips an assignment would otherwise infer a latch.
  always_comb begin
    pop = 1'b0;
    if (!reset) begin
      unique case (state)
        RUN:   pop = !empty && (!stream.m_valid || stream.m_ready);
        FLUSH: pop = !empty;
        default: pop = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush) state_next = FLUSH;
      FLUSH:   if (count_next == '0) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= RUN;
      count          <= '0;
      stream.m_valid <= 1'b0;
      stream.m_data  <= '0;
      overflow       <= 1'b0;
      flush_done     <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      flush_done <= (state == FLUSH) && (count_next == '0);

      if (push && full && !pop) overflow <= 1'b1;

      if (state == RUN) begin
        if (pop) begin
          stream.m_data  <= fifo_dout;
          stream.m_valid <= 1'b1;
        end else if (stream.m_valid && stream.m_ready) begin
          stream.m_valid <= 1'b0;
        end
        // Entering FLUSH drops whatever sits in the output register.
        if (flush) stream.m_valid <= 1'b0;
      end else begin
        stream.m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_reader
//   Directed bench for fifo_reader. A simple 256-entry fifo lives in the bench
//   to supply fifo_dout; every expected value below is a hand-derived constant.
//   Inputs change 1 ns after the rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic [7:0] push_data;
  logic [7:0] fifo_dout;
  logic       pop;
  logic       flush;
  logic [8:0] count;
  logic       empty, full, overflow, flush_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(8)) s_if ();

  fifo_reader #(.DEPTH(256), .SIZE(8), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .fifo_dout  (fifo_dout),
    .pop        (pop),
    .flush      (flush),
    .stream     (s_if),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .flush_done (flush_done)
  );

  // Companion fifo, reset together with the DUT.
  logic [7:0] mem [256];
  logic [7:0] rd_ptr, wr_ptr;
  int         fcnt;
  logic       fifo_wr;

  assign fifo_wr   = push && (fcnt < 256 || pop);
  assign fifo_dout = mem[rd_ptr];

  always @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fcnt   <= 0;
    end else begin
      if (fifo_wr) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 8'd1;
      fcnt <= fcnt + int'(fifo_wr) - int'(pop);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pops;
    reset = 1'b1; push = 1'b0; push_data = '0; flush = 1'b0; s_if.m_ready = 1'b0;
    tick(); tick();

    // Reset state, pop low while reset is held.
    check("rst_pop",   32'(pop), 0);
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(s_if.m_valid), 0);
    check("rst_data",  32'(s_if.m_data), 0);
    check("rst_ovf",   32'(overflow), 0);
    check("rst_fdone", 32'(flush_done), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full",  32'(full), 0);
    reset = 1'b0;

    // Single entry: one pop, data one edge after the push edge.
    s_if.m_ready = 1'b1; push = 1'b1; push_data = 8'hA5;
    tick();
    push = 1'b0; #1;
    check("single_pop",   32'(pop), 1);
    check("single_cnt1",  32'(count), 1);
    check("single_nval",  32'(s_if.m_valid), 0);
    tick();
    check("single_valid", 32'(s_if.m_valid), 1);
    check("single_data",  32'(s_if.m_data), 32'hA5);
    check("single_cnt0",  32'(count), 0);
    check("single_pop0",  32'(pop), 0);
    tick();
    check("single_drain", 32'(s_if.m_valid), 0);
    s_if.m_ready = 1'b0;

    // Backpressure: 01..04 pushed, consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      push = 1'b1; push_data = 8'(i);
      tick();
    end
    push = 1'b0; #1;
    check("bp_data",  32'(s_if.m_data), 1);
    check("bp_valid", 32'(s_if.m_valid), 1);
    check("bp_count", 32'(count), 3);
    check("bp_pop",   32'(pop), 0);
    s_if.m_ready = 1'b1; #1;
    check("bp_pop_go", 32'(pop), 1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("bp_seq_data",  32'(s_if.m_data), 32'(i));
      check("bp_seq_valid", 32'(s_if.m_valid), 1);
    end
    tick();
    check("bp_end_valid", 32'(s_if.m_valid), 0);
    check("bp_end_empty", 32'(empty), 1);
    s_if.m_ready = 1'b0;

    // Full and overflow with the consumer stalled.
    for (int i = 0; i < 256; i++) begin
      push = 1'b1; push_data = 8'(i);
      tick();
    end
    check("full_cnt255", 32'(count), 255);
    check("full_not",    32'(full), 0);
    push_data = 8'h00;
    tick();
    check("full_cnt256", 32'(count), 256);
    check("full_flag",   32'(full), 1);
    check("full_head",   32'(s_if.m_data), 0);
    check("full_novf",   32'(overflow), 0);
    tick();
    check("ovf_set",     32'(overflow), 1);
    check("ovf_cnt",     32'(count), 256);
    // Push and pop together at full: count holds, next entry moves out.
    s_if.m_ready = 1'b1;
    tick();
    check("full_pp_cnt",  32'(count), 256);
    check("full_pp_data", 32'(s_if.m_data), 1);
    push = 1'b0; s_if.m_ready = 1'b0;
    tick();
    check("ovf_sticky",  32'(overflow), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovf_clear",   32'(overflow), 0);
    check("ovf_rst_cnt", 32'(count), 0);

    // Concurrent push/accept at count 5.
    for (int i = 0; i < 6; i++) begin
      push = 1'b1; push_data = 8'(i);
      tick();
    end
    check("cc_pre_cnt",  32'(count), 5);
    check("cc_pre_data", 32'(s_if.m_data), 0);
    s_if.m_ready = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      push_data = 8'(5 + j);
      tick();
      check("cc_cnt",   32'(count), 5);
      check("cc_data",  32'(s_if.m_data), 32'(j));
      check("cc_valid", 32'(s_if.m_valid), 1);
    end
    s_if.m_ready = 1'b0;

    // Flush with 10 buffered entries and m_valid high.
    for (int i = 0; i < 5; i++) begin
      push_data = 8'(8'h40 + i);
      tick();
    end
    push = 1'b0;
    check("fl_pre_cnt", 32'(count), 10);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("fl_nvalid", 32'(s_if.m_valid), 0);
    check("fl_cnt",    32'(count), 10);
    pops = 0;
    for (int c = 0; c < 30; c++) begin
      if (pop) pops++;
      tick();
      if (flush_done) break;
    end
    check("fl_pops",   32'(pops), 10);
    check("fl_done",   32'(flush_done), 1);
    check("fl_empty",  32'(empty), 1);
    check("fl_hold",   32'(s_if.m_data), 20);
    check("fl_valid",  32'(s_if.m_valid), 0);
    tick();
    check("fl_done_1cyc", 32'(flush_done), 0);
    push = 1'b1; push_data = 8'h3C;
    tick();
    push = 1'b0;
    tick();
    check("fl_run_valid", 32'(s_if.m_valid), 1);
    check("fl_run_data",  32'(s_if.m_data), 32'h3C);

    // Flush with nothing buffered.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl0_nvalid", 32'(s_if.m_valid), 0);
    check("fl0_nodone", 32'(flush_done), 0);
    tick();
    check("fl0_done",   32'(flush_done), 1);

    // Reset in the middle of a flush at count 4.
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 8'(8'h50 + i);
      tick();
    end
    push = 1'b0;
    check("rf_pre_cnt", 32'(count), 4);
    flush = 1'b1;
    tick();
    flush = 1'b0; push = 1'b1;
    tick();
    check("rf_cnt4", 32'(count), 4);
    reset = 1'b1; flush = 1'b1; s_if.m_ready = 1'b1;
    tick();
    check("rf_cnt",   32'(count), 0);
    check("rf_valid", 32'(s_if.m_valid), 0);
    check("rf_ovf",   32'(overflow), 0);
    check("rf_pop",   32'(pop), 0);
    check("rf_fdone", 32'(flush_done), 0);
    reset = 1'b0; flush = 1'b0; push = 1'b1; push_data = 8'h77; s_if.m_ready = 1'b0;
    tick();
    push = 1'b0;
    tick();
    check("rf_run_valid", 32'(s_if.m_valid), 1);
    check("rf_run_data",  32'(s_if.m_data), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameters: DEPTH, 256, FIFO entry count (power of two); SIZE, 8, FIFO address width (log2 DEPTH); WIDTH, 8, data width.
REQ-002 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 push  input  1  copy of the write strobe driven to the companion fifo; one entry written per cycle high.
REQ-006 fifo_dout  input  WIDTH  combinational read data from the fifo (entry at its read pointer).
REQ-007 pop  output  WIDTH-independent 1  read strobe to the fifo; advances its read pointer on the edge it is high.
REQ-008 flush  input  1  request to discard all buffered entries.
REQ-009 m_data  output  WIDTH  registered output data.
REQ-010 m_valid  output  1  m_data holds an undelivered entry.
REQ-011 m_ready  input  1  downstream accepts m_data on an edge where m_valid and m_ready are both high.
REQ-012 count  output  SIZE+1  entries held in the fifo, excluding the entry in m_data.
REQ-013 empty, full  output  1 each  count==0; count==DEPTH.
REQ-014 overflow  output  1  sticky error flag.
REQ-015 flush_done  output  1  single-cycle pulse at end of flush.

Function
REQ-016 FSM SHALL have two states, RUN and FLUSH; RUN after reset.
REQ-017 In RUN, pop SHALL be combinational: pop = (count!=0) && (!m_valid || m_ready).
REQ-018 On an edge with pop high in RUN, m_data SHALL load fifo_dout and m_valid SHALL become 1.
REQ-019 On an edge with m_valid && m_ready && !pop, m_valid SHALL become 0; m_data holds its value.
REQ-020 count SHALL update each edge as count + push_eff - pop; push_eff = push && (count!=DEPTH || pop).
REQ-021 Push and pop on the same edge SHALL leave count unchanged.
REQ-022 push with count==DEPTH and pop low SHALL set overflow and leave count at DEPTH; overflow clears only on reset.
REQ-023 Latency: push on edge k into empty fifo, m_valid low, m_ready don't-care -> pop high during cycle k..k+1, m_valid=1 after edge k+1.
REQ-024 Throughput: with count>0 and m_ready held high, SHALL deliver one entry per cycle with no bubbles.
REQ-025 flush sampled high in RUN SHALL transition to FLUSH on that edge and clear m_valid on that edge.
REQ-026 In FLUSH, pop SHALL equal (count!=0), m_valid SHALL stay 0, m_data SHALL hold; flush input is ignored.
REQ-027 FLUSH SHALL return to RUN on the edge where next count is 0, pulsing flush_done for the following cycle; flush with count==0 gives RUN after one cycle and flush_done pulse.
REQ-028 Pushes during FLUSH SHALL be counted and discarded; FLUSH persists while pushes keep count nonzero.
REQ-029 full and empty SHALL be derived combinationally from count only.

Reset
REQ-030 reset high on an edge SHALL force: state RUN, count 0, m_valid 0, m_data 0, overflow 0, flush_done 0; pop low in the reset cycle.
REQ-031 Reset asserted mid-transfer or mid-flush SHALL take priority over push, pop, flush and m_ready on that edge.
REQ-032 The companion fifo SHALL be reset in the same cycle; this block does not reset it.

Verification
REQ-033 Single: reset, push 0xA5 once, m_ready=1 -> pop high one cycle, m_valid=1 with m_data=0xA5 one edge after push, count returns 0.
REQ-034 Backpressure: push 4 entries 0x01..0x04, m_ready=0 -> m_data=0x01 held, count=3, pop low; raise m_ready -> 0x01..0x04 in consecutive cycles, then m_valid=0.
REQ-035 Full/overflow: m_ready=0, push 257 times (DEPTH=256) -> first pushed entry in m_data, count=255 then 256 after one more push, full=1; next push with no pop -> overflow=1, count stays 256.
REQ-036 Concurrent: count=5, push and accept every cycle for 20 cycles -> count stays 5, data order preserved, no gaps.
REQ-037 Flush: count=10, m_valid=1, pulse flush -> m_valid=0 next edge, pop high 10 cycles, then flush_done pulse, empty=1, state RUN.
REQ-038 Reset mid-flush: assert reset at count=4 in FLUSH -> after edge count=0, m_valid=0, overflow=0, pop low, state RUN.
